mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum cycles spent in REQ plus WAIT before the transaction is abandoned.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 ex_i  input  execute_signals_t  execute-stage result; ex_i.valid qualifies it.
REQ-005 ex_ready_o  output  1  stage can accept ex_i this cycle.
REQ-006 dmem_req_o  output  1  data-memory request, held until granted.
REQ-007 dmem_we_o  output  1  request is a store.
REQ-008 dmem_addr_o  output  32  word-aligned address {mem_addr[31:2],2'b00}.
REQ-009 dmem_be_o  output  4  byte enables.
REQ-010 dmem_wdata_o  output  32  store data, lane-replicated.
REQ-011 dmem_gnt_i  input  1  request accepted.
REQ-012 dmem_rvalid_i  input  1  response valid; load data or store acknowledge.
REQ-013 dmem_rdata_i  input  32  load data word.
REQ-014 wb_valid_o, wb_we_o, wb_rd_o[4:0], wb_data_o[31:0]  outputs  register-file writeback port.
REQ-015 bus_err_o  output  1  one-cycle pulse on timeout.
REQ-016 misalign_o  output  1  one-cycle pulse on a misaligned access; present only with MEM_MISALIGN_TRAP_EN.

Function
REQ-017 States: IDLE, REQ, WAIT, WB; ex_ready_o=1 only in IDLE.
REQ-018 Accept on ex_i.valid && ex_ready_o; capture ex_i; opcode=inst[6:0], funct3=inst[14:12], offset=mem_addr[1:0].
REQ-019 Non-memory instruction (not OP_LOAD, mem_write=0): IDLE->WB; wb_valid_o=1 for exactly one cycle, one cycle after accept; wb_data_o=result.
REQ-020 Load (opcode OP_LOAD) or store (mem_write=1): IDLE->REQ; dmem_req_o held at 1 in REQ until dmem_gnt_i, then REQ->WAIT.
REQ-021 WAIT: on dmem_rvalid_i, load->WB; store->IDLE with no writeback.
REQ-022 Byte enables: SB 4'b0001<<offset; SH 4'b0011<<{offset[1],1'b0}; SW 4'b1111.
REQ-023 Store data: SB {4{byte}}; SH {2{half}}; SW word.
REQ-024 Load extract by funct3: LB 000 and LH 001 sign-extend; LW 010; LBU 100 and LHU 101 zero-extend; lane chosen by offset.
REQ-025 wb_we_o = reg_write && rd!=0; wb_rd_o=rd; wb_we_o=0 whenever wb_valid_o=0.
REQ-026 Minimum load latency: accept at cycle 0, REQ at cycle 1 with gnt, WAIT at cycle 2 with rvalid, wb_valid_o at cycle 3.
REQ-027 Timeout counter: cleared on entry to REQ, increments in REQ and WAIT; on reaching TIMEOUT_CYCLES -> bus_err_o pulse, go to IDLE, no writeback, dmem_req_o deasserted.
REQ-028 dmem_rvalid_i outside WAIT is ignored; dmem_gnt_i outside REQ is ignored.
REQ-029 All outputs are registered; WB->IDLE unconditionally after one cycle.

Reset
REQ-030 rst_i asserted: state=IDLE, counter=0; all outputs 0 except ex_ready_o=1 after reset deasserts.
REQ-031 Reset mid-transaction abandons it; a late rvalid after reset is ignored; no writeback is produced.

Configuration
REQ-032 MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with offset[0]=1, or LW/SW with offset!=0 -> no memory request, misalign_o pulses one cycle after accept, no writeback, return to IDLE.
REQ-033 MEM_MISALIGN_TRAP_EN undefined: misalign_o is absent; LW/SW ignore offset; halfword accesses use offset[1] only.

Structure
REQ-034 core_types_pkg gains mem_wb_state_e, a mem_size_e decoded from funct3, and a wb_signals_t struct {valid, we, rd, data}.
REQ-035 Sub-module load_align: combinational extraction and extension of dmem_rdata_i by funct3 and offset.

Verification
REQ-036 ALU op: result=0x1234, rd=5, reg_write=1 -> wb_valid_o at cycle 1; wb_data_o=0x1234; wb_we_o=1.
REQ-037 LB at addr 0x103; rdata=0x80FF_0000; gnt immediate; rvalid next cycle -> dmem_addr_o=0x100, be=4'b1000, wb_data_o=0xFFFF_FF80 at cycle 3.
REQ-038 SH at addr 0x22; data 0xABCD; gnt delayed 3 cycles -> req held 3 cycles, be=4'b1100, wdata=0xABCD_ABCD, no wb_valid_o.
REQ-039 Load with no rvalid, TIMEOUT_CYCLES=8 -> bus_err_o pulse after 8 cycles; then ex_ready_o=1.
REQ-040 rst_i asserted while in WAIT, then rvalid -> no writeback; outputs 0; with the macro, LW at 0x102 -> misalign_o=1 and dmem_req_o stays 0.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core types for the memory/writeback stage: execute payload,
// stage FSM states, access size decode and writeback port bundle.
package core_types_pkg;

    localparam int unsigned XLEN    = 32;
    localparam logic [6:0]  OP_LOAD = 7'b0000011;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
    } execute_signals_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } mem_wb_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_signals_t;

    // Access width from funct3; the reserved encoding behaves as a word.
    function automatic mem_size_e decode_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic is_load(input logic [XLEN-1:0] inst);
        return inst[6:0] == OP_LOAD;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: picks the addressed lane of the read word and
// sign- or zero-extends it according to funct3.
module load_align
    import core_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select and extension; funct3[2] marks the unsigned variants.
    always_comb begin
        byte_v = rdata[{offset, 3'b000} +: 8];
        half_v = rdata[{offset[1], 4'b0000} +: 16];
        case (decode_size(funct3))
            SIZE_BYTE: data_c = funct3[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_HALF: data_c = funct3[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default:   data_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / writeback stage: issues data-memory requests for loads and
// stores, aligns load data, and drives the register-file writeback port.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses trap
// instead of being issued).
module mem_wb_stage
    import core_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  execute_signals_t ex_i,
    output logic             ex_ready_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [31:0]      dmem_addr_o,
    output logic [3:0]       dmem_be_o,
    output logic [31:0]      dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic             wb_valid_o,
    output logic             wb_we_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             bus_err_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic             misalign_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_wb_state_e    state_q, state_d;
    execute_signals_t cap_q;
    execute_signals_t txn;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       funct3;
    logic [1:0]       offset;
    mem_size_e        size;
    logic             is_mem;
    logic             accept;
    logic             timeout_hit;
    logic             misalign_hit;
    logic [31:0]      load_data_c;
    logic             unused_txn;

    logic             ex_ready_d, req_d, we_d, bus_err_d;
    logic [31:0]      addr_d, wdata_d;
    logic [3:0]       be_d;
    wb_signals_t      wb_d, wb_q;

    // In IDLE the transaction is the one being offered; afterwards it is the captured copy.
    assign txn    = (state_q == ST_IDLE) ? ex_i : cap_q;
    assign funct3 = txn.inst[14:12];
    assign offset = txn.mem_addr[1:0];
    assign size   = decode_size(funct3);
    assign is_mem = is_load(txn.inst) || txn.mem_write;
    assign accept = (state_q == ST_IDLE) && ex_i.valid;
    assign unused_txn = ^{txn.valid, txn.inst[31:15], txn.inst[11:7]};

    // Out of budget on the last allowed cycle, unless the response lands on it.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                         ((state_q == ST_REQ) || (state_q == ST_WAIT && !dmem_rvalid_i));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_hit = accept && is_mem &&
                          (((size == SIZE_HALF) && offset[0]) ||
                           ((size == SIZE_WORD) && (offset != 2'b00)));
`else
    assign misalign_hit = 1'b0;
`endif

    load_align u_load_align (
        .rdata  (dmem_rdata_i),
        .funct3 (funct3),
        .offset (offset),
        .data_c (load_data_c)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_i.valid) begin
                    if (misalign_hit) state_d = ST_IDLE;
                    else if (is_mem)  state_d = ST_REQ;
                    else              state_d = ST_WB;
                end
            end
            ST_REQ: begin
                if (timeout_hit)     state_d = ST_IDLE;
                else if (dmem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dmem_rvalid_i)    state_d = is_load(txn.inst) ? ST_WB : ST_IDLE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next output values, derived from the state being entered.
    always_comb begin
        ex_ready_d = (state_d == ST_IDLE);
        req_d      = 1'b0;
        we_d       = 1'b0;
        addr_d     = '0;
        be_d       = '0;
        wdata_d    = '0;
        wb_d       = '0;
        bus_err_d  = timeout_hit;
        if (state_d == ST_REQ) begin
            req_d  = 1'b1;
            we_d   = txn.mem_write;
            addr_d = {txn.mem_addr[31:2], 2'b00};
            case (size)
                SIZE_BYTE: begin
                    be_d    = 4'b0001 << offset;
                    wdata_d = {4{txn.store_data[7:0]}};
                end
                SIZE_HALF: begin
                    be_d    = 4'b0011 << {offset[1], 1'b0};
                    wdata_d = {2{txn.store_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = txn.store_data;
                end
            endcase
        end
        if (state_d == ST_WB) begin
            wb_d.valid = 1'b1;
            wb_d.we    = txn.reg_write && (txn.rd != 5'd0);
            wb_d.rd    = txn.rd;
            wb_d.data  = is_load(txn.inst) ? load_data_c : txn.result;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_ready_o   <= 1'b1;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_q         <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            ex_ready_o   <= ex_ready_d;
            dmem_req_o   <= req_d;
            dmem_we_o    <= we_d;
            dmem_addr_o  <= addr_d;
            dmem_be_o    <= be_d;
            dmem_wdata_o <= wdata_d;
            wb_q         <= wb_d;
            bus_err_o    <= bus_err_d;
        end
    end

    assign wb_valid_o = wb_q.valid;
    assign wb_we_o    = wb_q.we;
    assign wb_rd_o    = wb_q.rd;
    assign wb_data_o  = wb_q.data;

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalignment trap pulse, one cycle after the offending accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) misalign_o <= 1'b0;
        else       misalign_o <= misalign_hit;
    end
`endif

    // Capture the accepted execute payload.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       cap_q <= '0;
        else if (accept) cap_q <= ex_i;
    end

    // Cycles spent in REQ plus WAIT for the current access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                             cnt_q <= '0;
        else if (state_d == ST_REQ && state_q != ST_REQ)       cnt_q <= '0;
        else if (state_q == ST_REQ || state_q == ST_WAIT)      cnt_q <= cnt_q + CNT_W'(1);
        else                                                   cnt_q <= '0;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, randomized transactions
// against a reference model, and timeout / reset / misalignment sequences.
module tb_mem_wb_stage;
    import core_types_pkg::*;

    localparam int unsigned TO = 8;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic             clk = 1'b0;
    logic             rst;
    execute_signals_t ex_i;
    logic             ex_ready_o, dmem_req_o, dmem_we_o;
    logic [31:0]      dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_data_o;
    logic [3:0]       dmem_be_o;
    logic             dmem_gnt_i, dmem_rvalid_i;
    logic             wb_valid_o, wb_we_o, bus_err_o;
    logic [4:0]       wb_rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic             misalign_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string            name;
        execute_signals_t e;
        int               gd;
        int               rdl;
        logic [31:0]      rdata;
        logic             mem;
        logic [31:0]      addr;
        logic [3:0]       be;
        logic [31:0]      wdata;
        logic             wb;
        logic             we;
        logic [31:0]      data;
    } vec_t;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ex_i          (ex_i),
        .ex_ready_o    (ex_ready_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_we_o       (wb_we_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .bus_err_o     (bus_err_o)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic execute_signals_t mk_ex(input logic [6:0] opc, input logic [2:0] f3,
            input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] res,
            input logic [4:0] rd, input logic rw, input logic mw);
        execute_signals_t e;
        e            = '0;
        e.inst       = {17'h0, f3, rd, opc};
        e.mem_addr   = addr;
        e.store_data = sd;
        e.result     = res;
        e.rd         = rd;
        e.reg_write  = rw;
        e.mem_write  = mw;
        return e;
    endfunction

    function automatic vec_t mk_vec(input string name, input execute_signals_t e,
            input int gd, input int rdl, input logic [31:0] rdata, input logic mem,
            input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
            input logic wb, input logic we, input logic [31:0] data);
        vec_t v;
        v.name = name; v.e = e; v.gd = gd; v.rdl = rdl; v.rdata = rdata; v.mem = mem;
        v.addr = addr; v.be = be; v.wdata = wdata; v.wb = wb; v.we = we; v.data = data;
        return v;
    endfunction

    // Reference model: expected bus and writeback behaviour from the access rules.
    function automatic vec_t model(input execute_signals_t e, input int gd, input int rdl,
            input logic [31:0] rdata);
        vec_t        v;
        logic [2:0]  f3;
        int          nbytes, lane;
        logic [31:0] mask, val;
        logic        ld;
        f3     = e.inst[14:12];
        ld     = (e.inst[6:0] == 7'b0000011);
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lane   = (nbytes == 4) ? 0 : (nbytes == 2) ? (int'(e.mem_addr[1:0]) & 2) : int'(e.mem_addr[1:0]);
        v.name  = "rnd";
        v.e     = e;
        v.gd    = gd;
        v.rdl   = rdl;
        v.rdata = rdata;
        v.mem   = ld || e.mem_write;
        v.addr  = e.mem_addr & 32'hFFFF_FFFC;
        v.be    = 4'(((1 << nbytes) - 1) << lane);
        for (int i = 0; i < 4; i++)
            v.wdata[8*i +: 8] = e.store_data[8*(i % nbytes) +: 8];
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val  = (rdata >> (8 * lane)) & mask;
        if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
        v.wb   = ld || !e.mem_write;
        v.we   = e.reg_write && (e.rd != 5'd0);
        v.data = ld ? val : e.result;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        ex_i       = v.e;
        ex_i.valid = 1'b1;
        tick();
        ex_i = '0;
        if (v.mem) begin
            for (int k = 0; k <= v.gd; k++) begin
                chk({v.name, " req"},   32'(dmem_req_o),  32'd1);
                chk({v.name, " addr"},  dmem_addr_o,      v.addr);
                chk({v.name, " be"},    32'(dmem_be_o),   32'(v.be));
                chk({v.name, " wdata"}, dmem_wdata_o,     v.wdata);
                chk({v.name, " we"},    32'(dmem_we_o),   32'(v.e.mem_write));
                dmem_gnt_i    = (k == v.gd);
                dmem_rvalid_i = 1'($urandom_range(0, 1));
                dmem_rdata_i  = $urandom;
                tick();
            end
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            chk({v.name, " req_drop"}, 32'(dmem_req_o), 32'd0);
            for (int k = 0; k <= v.rdl; k++) begin
                chk({v.name, " early_wb"}, 32'(wb_valid_o), 32'd0);
                dmem_rvalid_i = (k == v.rdl);
                dmem_rdata_i  = (k == v.rdl) ? v.rdata : $urandom;
                dmem_gnt_i    = 1'($urandom_range(0, 1));
                tick();
            end
            dmem_rvalid_i = 1'b0;
            dmem_gnt_i    = 1'b0;
        end
        if (v.wb) begin
            chk({v.name, " wb_valid"}, 32'(wb_valid_o), 32'd1);
            chk({v.name, " wb_we"},    32'(wb_we_o),    32'(v.we));
            chk({v.name, " wb_rd"},    32'(wb_rd_o),    32'(v.e.rd));
            chk({v.name, " wb_data"},  wb_data_o,       v.data);
            tick();
        end
        chk({v.name, " wb_end"},  32'(wb_valid_o), 32'd0);
        chk({v.name, " ready"},   32'(ex_ready_o), 32'd1);
        chk({v.name, " bus_err"}, 32'(bus_err_o),  32'd0);
    endtask

    vec_t tbl[11];

    initial begin
        vec_t             v;
        execute_signals_t e;
        logic [2:0]       ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]       f3;
        logic [31:0]      addr;
        int               kind;

        tbl[0]  = mk_vec("alu",     mk_ex(OPC_ALU, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 1'b0),
                         0, 0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1234);
        tbl[1]  = mk_vec("alu_rd0", mk_ex(OPC_ALU, 3'b000, 32'h0, 32'h0, 32'hDEAD, 5'd0, 1'b1, 1'b0),
                         0, 0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_DEAD);
        tbl[2]  = mk_vec("lb",      mk_ex(OP_LOAD, 3'b000, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0),
                         0, 0, 32'h80FF_0000, 1'b1, 32'h100, 4'b1000, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80);
        tbl[3]  = mk_vec("lbu",     mk_ex(OP_LOAD, 3'b100, 32'h101, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0),
                         1, 0, 32'h1234_9A78, 1'b1, 32'h100, 4'b0010, 32'h0, 1'b1, 1'b1, 32'h0000_009A);
        tbl[4]  = mk_vec("lh",      mk_ex(OP_LOAD, 3'b001, 32'h202, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0),
                         0, 1, 32'h8001_7FFF, 1'b1, 32'h200, 4'b1100, 32'h0, 1'b1, 1'b1, 32'hFFFF_8001);
        tbl[5]  = mk_vec("lhu",     mk_ex(OP_LOAD, 3'b101, 32'h200, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0),
                         0, 0, 32'h8001_F00D, 1'b1, 32'h200, 4'b0011, 32'h0, 1'b1, 1'b1, 32'h0000_F00D);
        tbl[6]  = mk_vec("lw",      mk_ex(OP_LOAD, 3'b010, 32'h3FC, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0),
                         0, 2, 32'hCAFE_BABE, 1'b1, 32'h3FC, 4'b1111, 32'h0, 1'b1, 1'b1, 32'hCAFE_BABE);
        tbl[7]  = mk_vec("sh",      mk_ex(OPC_STORE, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 5'd0, 1'b0, 1'b1),
                         3, 1, 32'h0, 1'b1, 32'h20, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0);
        tbl[8]  = mk_vec("sb",      mk_ex(OPC_STORE, 3'b000, 32'h5, 32'h1234_567A, 32'h0, 5'd0, 1'b0, 1'b1),
                         0, 0, 32'h0, 1'b1, 32'h4, 4'b0010, 32'h7A7A_7A7A, 1'b0, 1'b0, 32'h0);
        tbl[9]  = mk_vec("sw",      mk_ex(OPC_STORE, 3'b010, 32'h40, 32'h0123_4567, 32'h0, 5'd0, 1'b0, 1'b1),
                         1, 2, 32'h0, 1'b1, 32'h40, 4'b1111, 32'h0123_4567, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk_vec("lb_rd0",  mk_ex(OP_LOAD, 3'b000, 32'h100, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0),
                         0, 0, 32'h0000_007F, 1'b1, 32'h100, 4'b0001, 32'h0, 1'b1, 1'b0, 32'h0000_007F);

        rst           = 1'b1;
        ex_i          = '0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rst ready",   32'(ex_ready_o), 32'd1);
        chk("rst req",     32'(dmem_req_o), 32'd0);
        chk("rst wb",      32'(wb_valid_o), 32'd0);
        chk("rst bus_err", 32'(bus_err_o),  32'd0);
        chk("rst addr",    dmem_addr_o,     32'd0);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Load granted but never answered: abandoned after TO cycles.
        ex_i = mk_ex(OP_LOAD, 3'b010, 32'h80, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
        ex_i.valid = 1'b1;
        tick();
        ex_i = '0;
        for (int c = 1; c <= int'(TO); c++) begin
            chk("to_wait bus_err_early", 32'(bus_err_o), 32'd0);
            dmem_gnt_i = (c == 1);
            tick();
            dmem_gnt_i = 1'b0;
        end
        chk("to_wait bus_err", 32'(bus_err_o),  32'd1);
        chk("to_wait ready",   32'(ex_ready_o), 32'd1);
        chk("to_wait wb",      32'(wb_valid_o), 32'd0);
        chk("to_wait req",     32'(dmem_req_o), 32'd0);
        tick();
        chk("to_wait pulse",   32'(bus_err_o),  32'd0);

        // Request never granted: request held, then dropped with the error pulse.
        ex_i = mk_ex(OPC_STORE, 3'b010, 32'h90, 32'h5555_AAAA, 32'h0, 5'd0, 1'b0, 1'b1);
        ex_i.valid = 1'b1;
        tick();
        ex_i = '0;
        for (int c = 1; c <= int'(TO); c++) begin
            chk("to_req req_held", 32'(dmem_req_o), 32'd1);
            tick();
        end
        chk("to_req bus_err", 32'(bus_err_o),  32'd1);
        chk("to_req req",     32'(dmem_req_o), 32'd0);
        chk("to_req ready",   32'(ex_ready_o), 32'd1);
        tick();

        // Reset while waiting for a response; the late response is ignored.
        ex_i = mk_ex(OP_LOAD, 3'b010, 32'h100, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        ex_i.valid = 1'b1;
        tick();
        ex_i       = '0;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("rstw req", 32'(dmem_req_o), 32'd0);
        chk("rstw wb",  32'(wb_valid_o), 32'd0);
        chk("rstw err", 32'(bus_err_o),  32'd0);
        #1;
        rst           = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_2222;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("rstw late_wb", 32'(wb_valid_o), 32'd0);
        chk("rstw ready",   32'(ex_ready_o), 32'd1);
        tick();
        chk("rstw late_wb2", 32'(wb_valid_o), 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned word load traps without touching the bus.
        ex_i = mk_ex(OP_LOAD, 3'b010, 32'h102, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
        ex_i.valid = 1'b1;
        tick();
        ex_i = '0;
        chk("mis pulse", 32'(misalign_o), 32'd1);
        chk("mis req",   32'(dmem_req_o), 32'd0);
        chk("mis wb",    32'(wb_valid_o), 32'd0);
        chk("mis ready", 32'(ex_ready_o), 32'd1);
        tick();
        chk("mis pulse_end", 32'(misalign_o), 32'd0);
        chk("mis req2",      32'(dmem_req_o), 32'd0);
`endif

        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            if (kind == 0) begin
                e = mk_ex(OPC_ALU, 3'($urandom), addr, $urandom, $urandom,
                          5'($urandom), 1'($urandom), 1'b0);
            end else begin
                f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
`ifdef MEM_MISALIGN_TRAP_EN
                if (f3[1:0] == 2'b01) addr[0]   = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
`endif
                if (kind == 1)
                    e = mk_ex(OP_LOAD, f3, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0);
                else
                    e = mk_ex(OPC_STORE, f3, addr, $urandom, $urandom, 5'($urandom), 1'b0, 1'b1);
            end
            v = model(e, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
            run_txn(v);
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("gap ready", 32'(ex_ready_o), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
